// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit port between NREQ byte producers.
// Define UART_ARB_TIMEOUT_EN to abort a launch the transmitter never acknowledges and flag err.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          ack,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     active,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     err
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            active_q, active_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q, last_d;
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  int              arb_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Search starts just past the last winner, so a re-raised request drops to lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      arb_idx = (int'(last_q) + k) % NREQ;
      if (!win_found && req[arb_idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    last_d     = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          tx_data_d       = req_data[8*int'(win_idx) +: 8];
          grant_d         = win_idx;
          last_d          = win_idx;
          ack_d[win_idx]  = 1'b1;
          tx_start_d      = 1'b1;
          state_d         = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == CW'(TIMEOUT)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
`endif
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      grant_q    <= '0;
      last_q     <= IDW'(NREQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign active   = active_q;
  assign grant_id = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transmitter stand-in, transaction-level reference model,
// per-cycle output comparison and hand-computed expectations for each scenario.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]  ack;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             active;
  logic [1:0]       grant_id;
  logic             err;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .active(active),
    .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transmitter stand-in: busy rises half a cycle after tx_start is seen, holds busy_len cycles.
  logic stuck  = 1'b0;
  logic glitch = 1'b0;
  int   busy_len = 10;
  int   busy_left = 0;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end else if (tx_start === 1'b1 && !stuck) begin
        tx_busy   = 1'b1;
        busy_left = busy_len;
      end else begin
        tx_busy = glitch;
      end
    end
  end

  // Reference model: phase 0 idle, 1 launched, 2 awaiting busy, 3 awaiting completion.
  int              m_phase = 0;
  logic [NREQ-1:0] m_ack   = '0;
  logic            m_start = 1'b0;
  logic [7:0]      m_data  = '0;
  int              m_grant = 0;
  int              m_last  = NREQ - 1;
  logic            m_err   = 1'b0;
  int              m_wait  = 0;
  logic            m_ok    = 1'b0;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = last + 1; i < NREQ; i++) if (r[i]) return i;
    for (int i = 0; i <= last; i++) if (r[i]) return i;
    return -1;
  endfunction

  initial begin
    int w;
    forever begin
      @(posedge clk);
      m_ack   = '0;
      m_start = 1'b0;
      if (!rst_n) begin
        m_phase = 0; m_data = '0; m_grant = 0; m_last = NREQ - 1; m_err = 1'b0; m_ok = 1'b1;
      end else if (m_phase == 0) begin
        w = rr_pick(req, m_last);
        if (w >= 0) begin
          m_data = req_data[8*w +: 8];
          m_grant = w; m_last = w; m_ack[w] = 1'b1; m_start = 1'b1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2; m_wait = 0;
      end else if (m_phase == 2) begin
        if (tx_busy) m_phase = 3;
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin m_phase = 0; m_err = 1'b1; end
        end
`endif
      end else begin
        if (!tx_busy) m_phase = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("ack", ack, m_ack);
        chk("tx_start", tx_start, m_start);
        chk("tx_data", tx_data, m_data);
        chk("active", active, m_phase != 0);
        chk("grant_id", grant_id, m_grant);
        chk("err", err, m_err);
        chk("ack_onehot", $countones(ack) <= 1, 1);
      end
    end
  end

  int ack_id;

  task automatic wait_ack(input int max);
    ack_id = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int b = 0; b < NREQ; b++) if (ack[b]) ack_id = b;
        return;
      end
    end
    chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!active) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 40 && tx_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ids[5];
    logic [7:0] dats[5];
    int n1, ns, n;
    rst_n = 1'b0; req = '0;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_active", active, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Busy glitch in IDLE must not start anything.
    glitch = 1'b1; @(negedge clk); @(negedge clk); glitch = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_idle_active", active, 0);

    // Single request.
    req_data[7:0] = 8'hA5; req = 4'b0001;
    wait_ack(20);
    chk("single_ack", ack, 4'b0001);
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_grant", grant_id, 0);
    req = '0;
    for (int i = 0; i < 30 && active; i++) begin
      chk("single_data_hold", tx_data, 8'hA5);
      @(negedge clk);
    end
    chk("single_back_idle", active, 0);

    // Round-robin with all requesters high.
    do_reset();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10}; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40);
      ids[k] = ack_id; dats[k] = tx_data;
    end
    req = '0;
    wait_idle(40);
    chk("rr_id0", ids[0], 0); chk("rr_id1", ids[1], 1); chk("rr_id2", ids[2], 2);
    chk("rr_id3", ids[3], 3); chk("rr_id4", ids[4], 0);
    chk("rr_d0", dats[0], 8'h10); chk("rr_d1", dats[1], 8'h21); chk("rr_d2", dats[2], 8'h32);
    chk("rr_d3", dats[3], 8'h43); chk("rr_d4", dats[4], 8'h10);

    // Wrap-around after serving requester 2.
    do_reset();
    req = 4'b0100;
    wait_ack(20); chk("wrap_g2", grant_id, 2);
    req = 4'b1011;
    wait_ack(40); chk("wrap_g3", grant_id, 3);
    wait_ack(40); chk("wrap_g0", grant_id, 0);
    wait_ack(40); chk("wrap_g1", grant_id, 1);
    req = '0;
    wait_idle(40);

    // Request raised and withdrawn while the previous byte is still on the wire.
    do_reset();
    req = 4'b0001;
    wait_ack(20);
    req = '0;
    repeat (4) @(negedge clk);
    n1 = 0; ns = 0;
    req = 4'b0010;
    repeat (2) begin @(negedge clk); if (ack[1]) n1++; if (tx_start) ns++; end
    req = '0;
    for (int i = 0; i < 30 && active; i++) begin
      @(negedge clk); if (ack[1]) n1++; if (tx_start) ns++;
    end
    repeat (5) begin @(negedge clk); if (ack[1]) n1++; if (tx_start) ns++; end
    chk("withdraw_ack1", n1, 0);
    chk("withdraw_start", ns, 0);

    // Reset in the middle of a frame.
    do_reset();
    req = 4'b0100;
    wait_ack(20);
    req = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ack", ack, 0);
    chk("midrst_start", tx_start, 0);
    chk("midrst_active", active, 0);
    chk("midrst_grant", grant_id, 0);
    chk("midrst_err", err, 0);
    for (int i = 0; i < 40 && tx_busy; i++) @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    wait_ack(20);
    chk("midrst_ack3", ack, 4'b1000);
    chk("midrst_grant3", grant_id, 3);
    req = '0;
    wait_idle(40);

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never answers: abort after TIMEOUT cycles of waiting, err sticks.
    do_reset();
    stuck = 1'b1;
    req = 4'b0010;
    wait_ack(20);
    req = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!active) break;
      n++;
    end
    chk("to_wait_cycles", n, 15);
    chk("to_err", err, 1);
    stuck = 1'b0;
    req = 4'b0001;
    wait_ack(20);
    req = '0;
    wait_idle(40);
    chk("to_err_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", err, 0);
`else
    n = 0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule
